// File: rtl/wasca_pio_pkg.sv
// Shared definitions for the WASCA debounced input PIO: register map,
// edge-capture mode encodings and the debounce counter sizing helper.
package wasca_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Counter must hold 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wasca_pio_debounce_bit.sv
// One input bit: synchroniser chain, sample register, disagreement counter
// and the debounced flop. deb_nxt_o exposes the value deb_o takes next edge.
module wasca_pio_debounce_bit
    import wasca_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic sync_o,
    output logic deb_o,
    output logic deb_nxt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   deb_q;
    logic                   deb_d;

    // raw_i is asynchronous; shift it through the metastability chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the debounced flop simply follows sync
            always_comb begin
                deb_d = sync_o;
            end
        end else begin : g_count
            localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic          samp_q;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Sample register and disagreement counter
            always_ff @(posedge clk) begin
                if (reset) begin
                    samp_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    samp_q <= sync_o;
                    cnt_q  <= cnt_d;
                end
            end

            // Any agreeing cycle restarts the count, so short glitches never land
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (samp_q != deb_q) begin
                    if (cnt_q == CNT_LAST) begin
                        deb_d = samp_q;
                        cnt_d = '0;
                    end else begin
                        deb_d = deb_q;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    deb_d = deb_q;
                    cnt_d = '0;
                end
            end
        end
    endgenerate

    // Debounced output flop
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb_d;
        end
    end

    assign deb_o     = deb_q;
    assign deb_nxt_o = deb_d;

endmodule

// File: rtl/wasca_pio_in_debounced.sv
// Avalon-MM debounced input PIO: per-bit debouncers, write-1-to-clear edge
// capture, interrupt mask and a registered read mux with one cycle of latency.
module wasca_pio_in_debounced
    import wasca_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] deb_nxt_s;
    logic [WIDTH-1:0] wr_bits_s;
    logic [WIDTH-1:0] edge_set_s;
    logic [WIDTH-1:0] edge_clr_s;
    logic             unused_wdata_s;

    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      rd_q, rd_d;
    logic             irq_q, irq_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        wasca_pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (in_port[g]),
            .sync_o    (sync_s[g]),
            .deb_o     (deb_s[g]),
            .deb_nxt_o (deb_nxt_s[g])
        );
    end

    assign wr_bits_s      = writedata[WIDTH-1:0];
    assign unused_wdata_s = ^writedata;

    // Select which debounced transitions count as a captured edge
    always_comb begin
        edge_set_s = '0;
        case (EDGE_MODE)
            EDGE_FALL: edge_set_s = deb_s & ~deb_nxt_s;
            EDGE_ANY:  edge_set_s = deb_s ^ deb_nxt_s;
            default:   edge_set_s = ~deb_s & deb_nxt_s;
        endcase
    end

    // Edge capture (set beats clear), mask update and interrupt level
    always_comb begin
        edge_clr_s = '0;
        mask_d     = mask_q;
        if (write && (address == ADDR_EDGE)) begin
            edge_clr_s = wr_bits_s;
        end else begin
            edge_clr_s = '0;
        end
        if (write && (address == ADDR_MASK)) begin
            mask_d = wr_bits_s;
        end else begin
            mask_d = mask_q;
        end
        edge_d = (edge_q & ~edge_clr_s) | edge_set_s;
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux, sampled every cycle; no read strobe is needed
    always_comb begin
        rd_d = 32'd0;
        case (address)
            ADDR_DATA: rd_d = 32'(deb_s);
            ADDR_RAW:  rd_d = 32'(sync_s);
            ADDR_MASK: rd_d = 32'(mask_q);
            ADDR_EDGE: rd_d = 32'(edge_q);
            default:   rd_d = 32'd0;
        endcase
    end

    // Register state
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
            mask_q <= '0;
            rd_q   <= 32'd0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_wasca_pio_in_debounced.sv
// Scoreboard bench: three configurations share the bus; expected readdata is
// queued when an address is driven and compared after the following edge.
module tb_wasca_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in8;
    logic [31:0] in32;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    wasca_pio_in_debounced #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_a (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_a), .in_port(in8), .irq(irq_a));

    wasca_pio_in_debounced #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_b (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_b), .in_port(in8), .irq(irq_b));

    wasca_pio_in_debounced #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0)) u_c (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_c), .in_port(in32), .irq(irq_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int inst, input logic [31:0] exp);
        sb_t it;
        it.tag  = tag;
        it.inst = inst;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic tick();
        sb_t         it;
        logic [31:0] got;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.inst)
                0:       got = rd_a;
                1:       got = rd_b;
                default: got = rd_c;
            endcase
            check_val(it.tag, got, it.exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = 32'd0;
    endtask

    initial begin
        reset     = 1'b1;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 32'd0;
        in8       = 8'hFF;
        in32      = 32'd0;

        // reset with inputs held high
        tick();
        tick();
        expect_rd("rst_rd", 0, 32'h0);
        tick();
        check_val("rst_irq_a", 32'(irq_a), 32'd0);
        check_val("rst_irq_b", 32'(irq_b), 32'd0);
        check_val("rst_irq_c", 32'(irq_c), 32'd0);
        reset = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            if (e == 6) expect_rd("rst_data_e6", 0, 32'h00);
            if (e == 7) expect_rd("rst_data_e7", 0, 32'hFF);
            tick();
        end
        address = 2'd3;
        expect_rd("rst_edge_a", 0, 32'hFF);
        expect_rd("rst_edge_b", 1, 32'hFF);
        expect_rd("rst_edge_c", 2, 32'h0);
        tick();

        // bit0 rising latency
        in8 = 8'h00;
        address = 2'd0;
        repeat (8) tick();
        do_write(2'd3, 32'hFFFF_FFFF);
        in8 = 8'h01;
        address = 2'd0;
        for (int e = 0; e <= 7; e++) begin
            if (e == 6) expect_rd("b0_data_e6", 0, 32'h00);
            if (e == 7) expect_rd("b0_data_e7", 0, 32'h01);
            tick();
        end
        address = 2'd3;
        expect_rd("b0_edge_a", 0, 32'h01);
        expect_rd("b0_edge_b", 1, 32'h01);
        tick();

        // 3-cycle glitch on bit1: visible raw, rejected by debouncer
        for (int e = 0; e <= 12; e++) begin
            in8     = (e < 3) ? 8'h03 : 8'h01;
            address = (e < 5) ? 2'd1 : 2'd0;
            if (e == 1) expect_rd("glitch_raw_e1", 0, 32'h01);
            if (e == 2) expect_rd("glitch_raw_e2", 0, 32'h03);
            if (e == 4) expect_rd("glitch_raw_e4", 0, 32'h03);
            if (e >= 5) expect_rd("glitch_deb", 0, 32'h01);
            tick();
        end
        address = 2'd3;
        expect_rd("glitch_edge", 0, 32'h01);
        tick();

        // irq masking
        check_val("irq_masked", 32'(irq_a), 32'd0);
        do_write(2'd2, 32'h0000_0001);
        check_val("irq_mask_lat", 32'(irq_a), 32'd0);
        address = 2'd2;
        expect_rd("mask_rd", 0, 32'h01);
        tick();
        check_val("irq_mask_on", 32'(irq_a), 32'd1);
        do_write(2'd3, 32'h0000_0001);
        check_val("irq_clr_lat", 32'(irq_a), 32'd1);
        address = 2'd3;
        expect_rd("edge_cleared", 0, 32'h00);
        tick();
        check_val("irq_clr_off", 32'(irq_a), 32'd0);
        in8 = 8'h00;
        repeat (8) tick();
        check_val("irq_fall_quiet", 32'(irq_a), 32'd0);
        in8 = 8'h01;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 6) check_val("irq_rise_e6", 32'(irq_a), 32'd0);
            if (e == 7) check_val("irq_rise_e7", 32'(irq_a), 32'd1);
        end

        // clear write coinciding with a new bit2 rise
        in8 = 8'h05;
        for (int e = 0; e <= 6; e++) begin
            if (e == 6) begin
                address   = 2'd3;
                writedata = 32'h0000_0004;
                write     = 1'b1;
            end
            tick();
        end
        write     = 1'b0;
        writedata = 32'd0;
        address   = 2'd3;
        expect_rd("set_beats_clr", 0, 32'h05);
        tick();
        check_val("irq_unmasked_bit2", 32'(irq_a), 32'd1);

        // falling edge on bit3: captured only in EDGE_ANY
        in8 = 8'h0D;
        repeat (8) tick();
        do_write(2'd3, 32'hFFFF_FFFF);
        in8 = 8'h05;
        repeat (8) tick();
        address = 2'd3;
        expect_rd("fall_rise_mode", 0, 32'h00);
        expect_rd("fall_any_mode", 1, 32'h08);
        tick();

        // mask width truncation
        do_write(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        expect_rd("mask_w8", 0, 32'h0000_00FF);
        expect_rd("mask_w32", 2, 32'hFFFF_FFFF);
        tick();

        // bypassed debouncer, 32 bits wide
        in32 = 32'hA5A5_1234;
        address = 2'd0;
        for (int e = 0; e <= 3; e++) begin
            if (e == 2) expect_rd("byp_e2", 2, 32'h0);
            if (e == 3) expect_rd("byp_e3", 2, 32'hA5A5_1234);
            tick();
        end
        do_write(2'd0, 32'h0);
        do_write(2'd1, 32'h0);
        address = 2'd0;
        expect_rd("ro_data_c", 2, 32'hA5A5_1234);
        expect_rd("ro_data_a", 0, 32'h05);
        tick();
        address = 2'd1;
        expect_rd("ro_raw_c", 2, 32'hA5A5_1234);
        tick();
        address = 2'd2;
        expect_rd("ro_mask_a", 0, 32'hFF);
        tick();

        // reset in the middle of a count restarts the full debounce
        in8 = 8'h45;
        address = 2'd0;
        repeat (4) tick();
        reset = 1'b1;
        expect_rd("midrst_rd", 0, 32'h0);
        tick();
        reset = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            if (e == 6) expect_rd("midrst_e6", 0, 32'h00);
            if (e == 7) expect_rd("midrst_e7", 0, 32'h45);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
